mp32_data_mem: RTL
==================

Name: mp32_data_mem

Overview:
- Data memory stage of the single-cycle MIPS datapath, directly upstream of the writeback select.
- Supplies `dout` to the writeback select and accepts stores from the datapath.
- Supports word, halfword and byte stores (`sw`/`sh`/`sb`) and loads (`lw`/`lh`/`lhu`/`lb`/`lbu`), little-endian.
- Synchronous write, combinational read with load extension applied.

Parameters:
- `ADDR_W`, default 10: word-address width; memory depth is 2**`ADDR_W` words.
- `DATA_W`, default 32: data width; fixed at 32, not overridable in practice.

Ports:
- `clk` input 1: system clock, rising edge active.
- `reset_n` input 1: asynchronous, active-low reset.
- `MemWrite` input 1: store enable, sampled at rising `clk`.
- `addr` input 32: byte address (ALU result).
- `din` input 32: store data (`rt` register value).
- `width` input 2: access size. 2'b00 word, 2'b01 half, 2'b10 byte, 2'b11 reserved.
- `load_unsigned` input 1: 1 means zero-extend, 0 means sign-extend sub-word loads.
- `dout` output 32: extended load data, to writeback select.
- `addr_err` output 1: misaligned or reserved-width access flag, combinational.

Behaviour:
- Storage: 2**`ADDR_W` x 32-bit words. Word index = `addr[ADDR_W+1:2]`. `addr` bits above `ADDR_W+1` are ignored, so addresses wrap modulo 4*2**`ADDR_W` bytes.
- Byte lanes are little-endian:
  - `addr[1:0]`=0 selects bits 7:0; 1 selects 15:8; 2 selects 23:16; 3 selects 31:24.
  - Halfword at `addr[1]`=0 is bits 15:0; at `addr[1]`=1 it is bits 31:16.
- `addr_err` = 1 when any of the following holds:
  - `width`=word and `addr[1:0]`!=0;
  - `width`=half and `addr[0]`=1;
  - `width`=2'b11.
- Otherwise `addr_err` = 0. `addr_err` is evaluated regardless of `MemWrite`.
- Write: on rising `clk`, when `reset_n`=1, `MemWrite`=1 and `addr_err`=0:
  - word: the whole word is replaced with `din`;
  - half: only the addressed 16-bit lane is replaced, with `din[15:0]`;
  - byte: only the addressed 8-bit lane is replaced, with `din[7:0]`.
  - Unaddressed lanes retain their contents.
- `MemWrite`=1 with `addr_err`=1: no write, memory unchanged.
- Read: combinational from the current array contents plus `addr`/`width`/`load_unsigned`, zero cycles of latency.
  - Word: the raw word.
  - Half/byte: the lane value, sign-extended from bit 15 or bit 7 when `load_unsigned`=0, zero-extended when 1.
  - `load_unsigned` is ignored for word accesses.
  - `dout` = 0 whenever `addr_err`=1.
- Read-during-write, same address: `dout` shows the old contents before the edge and the new contents after it; there is no write-through bypass.
- Reset: `reset_n`=0 asynchronously clears every word to 0.
  - `dout` therefore reads 0 during reset.
  - `addr_err` stays combinational and is unaffected by reset.
  - Reset asserted in the same cycle as a store: reset wins and the store is lost.
  - Writes resume at the first rising `clk` after `reset_n` returns to 1.
- No stall or handshake: one access per cycle, consistent with the single-cycle datapath.

Decomposition:
- Shared package `mp32_pkg` holds:
  - width codes `W_WORD`=2'b00, `W_HALF`=2'b01, `W_BYTE`=2'b10;
  - default `ADDR_W`;
  - `DATA_W`.
- One natural sub-module: `mp32_dm_load_ext`, combinational. It takes `rdata`, `addr[1:0]`, `width` and `load_unsigned`, and returns the extended `dout`.
- Lane write-mask generation stays in the top module.

Test Plan:
- Reset clears the array: with `reset_n`=0, read word at `addr` 0x0000_0010 -> `dout`=0x0000_0000 and `addr_err`=0.
- Word store then load: `sw` 0xDEAD_BEEF at 0x0000_0004, then `lw` at 0x4 -> `dout`=0xDEAD_BEEF. Words at 0x0 and 0x8 still read 0.
- Sub-word stores:
  - `sb` 0x80 to 0x0000_0101 on a word previously holding 0x1122_3344 -> word reads 0x1122_8044.
  - `lb` at 0x101 -> 0xFFFF_FF80; `lbu` -> 0x0000_0080.
  - `sh` 0xFEDC to 0x102 -> word 0xFEDC_8044; `lh` at 0x102 -> 0xFFFF_FEDC; `lhu` -> 0x0000_FEDC.
- Misaligned and reserved accesses:
  - `sw` to 0x0000_0006 -> `addr_err`=1, memory unchanged, `dout`=0.
  - `lh` at 0x3 -> `addr_err`=1.
  - `width`=2'b11 at any address -> `addr_err`=1 with no write.
- Wrap-around: with `ADDR_W`=10, `sw` 0x1234_5678 at 0x0000_1000 -> `lw` at 0x0000_0000 returns 0x1234_5678.
- Reset mid-operation: `reset_n` falls between edges while `MemWrite`=1 and data 0xAAAA_AAAA targets 0x20. After release, `lw` at 0x20 -> 0 and the whole array reads 0. The next store succeeds.

Source files
------------

// File: rtl/mp32_pkg.sv
// mp32 shared definitions: access width codes and
// data memory sizing defaults.
package mp32_pkg;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  localparam int DM_ADDR_W = 10;
  localparam int DM_DATA_W = 32;

endpackage

// File: rtl/mp32_dm_load_ext.sv
// mp32 data memory load path: lane select plus
// sign/zero extension for half and byte loads.
module mp32_dm_load_ext
  import mp32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  width,
  input  logic        load_unsigned,
  output logic [31:0] dout
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;

  always_comb begin
    byte_v = rdata[7:0];
    case (lane)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
  end

  assign half_v = lane[1] ? rdata[31:16] : rdata[15:0];
  assign sgn    = ~load_unsigned;

  always_comb begin
    dout = '0;
    case (width)
      W_WORD:  dout = rdata;
      W_HALF:  dout = {{16{sgn & half_v[15]}}, half_v};
      W_BYTE:  dout = {{24{sgn & byte_v[7]}}, byte_v};
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/mp32_data_mem.sv
// mp32 data memory: byte-lane stores with synchronous
// write, combinational extended loads, async clear.
module mp32_data_mem
  import mp32_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        width,
  input  logic              load_unsigned,
  output logic [DATA_W-1:0] dout,
  output logic              addr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] widx;
  logic [3:0]        wmask;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [31:0]       ext;
  logic              unused_hi;

  assign widx      = addr[ADDR_W+1:2];
  assign unused_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    addr_err = 1'b0;
    case (width)
      W_WORD:  addr_err = |addr[1:0];
      W_HALF:  addr_err = addr[0];
      W_BYTE:  addr_err = 1'b0;
      default: addr_err = 1'b1;
    endcase
  end

  // Lanes are forced off on error so a bad store is dropped.
  always_comb begin
    wmask = 4'h0;
    wdata = din;
    case (width)
      W_WORD: wmask = 4'hF;
      W_HALF: begin
        wmask = addr[1] ? 4'hC : 4'h3;
        wdata = {2{din[15:0]}};
      end
      W_BYTE: begin
        wmask = 4'b0001 << addr[1:0];
        wdata = {4{din[7:0]}};
      end
      default: wmask = 4'h0;
    endcase
    if (addr_err || !MemWrite) wmask = 4'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (wmask[b])
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[widx];

  mp32_dm_load_ext u_ext (
    .rdata         (rdata),
    .lane          (addr[1:0]),
    .width         (width),
    .load_unsigned (load_unsigned),
    .dout          (ext)
  );

  assign dout = addr_err ? '0 : ext;

endmodule
